// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: the tracked-entry
// record and the forwarding-select encoding.
package pipe_hazard_pkg;

  localparam int SB_REG_ADDR_W = 5;
  localparam int SB_DEPTH      = 3;
  localparam int FWD_W         = $clog2(SB_DEPTH + 1);
  localparam int FWD_RF        = 0;

  typedef struct packed {
    logic                     valid;
    logic [SB_REG_ADDR_W-1:0] dst;
    logic                     load;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Per-operand priority encoder over the tracking pipe: reports the youngest
// in-flight entry whose destination matches the source register.
module sb_match
  import pipe_hazard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDX_W = $clog2(SB_DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0]    pipe_i,
  input  logic [SB_REG_ADDR_W-1:0] src_i,
  input  logic                     used_i,
  output logic                     hit_o,
  output logic [IDX_W-1:0]         idx_o,
  output logic                     load_o
);

  // Scan oldest to youngest so the lowest matching index is the last written.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (used_i && pipe_i[j].valid && (pipe_i[j].dst == src_i)) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(j);
        load_o = pipe_i[j].load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Depth-generic hazard/forwarding controller: tracks in-flight destinations,
// picks the youngest forwarding source per operand and raises load-use stalls.
module hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter  int REG_ADDR_W   = SB_REG_ADDR_W,
  parameter  int DEPTH        = SB_DEPTH,
  parameter  int NUM_SRC      = 2,
  parameter  int LOAD_LAT     = 1,
  parameter  int FLUSH_STAGES = 2,
  localparam int SEL_W        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic                          issue_wr,
  input  logic                          issue_load,
  input  logic [REG_ADDR_W-1:0]         issue_dst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [15:0]                   stall_cnt
);

  sb_entry_t [DEPTH-1:0]      pipe_q, pipe_d;
  logic [NUM_SRC*SEL_W-1:0]   fwd_q, fwd_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [NUM_SRC-1:0]         hit, is_load, op_stall;
  logic [SEL_W-1:0]           idx [NUM_SRC];
  logic                       advance;
  sb_entry_t                  new_entry;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sb_match #(
      .DEPTH (DEPTH),
      .IDX_W (SEL_W)
    ) u_match (
      .pipe_i (pipe_q),
      .src_i  (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .used_i (src_used[i]),
      .hit_o  (hit[i]),
      .idx_o  (idx[i]),
      .load_o (is_load[i])
    );
    // A load still younger than LOAD_LAT has no result to forward yet.
    assign op_stall[i] = hit[i] && is_load[i] && (int'(idx[i]) < LOAD_LAT);
  end

  assign stall     = issue_valid && !flush && (|op_stall);
  assign advance   = issue_valid && !stall && !flush;
  assign new_entry = '{valid: issue_wr && (issue_dst != '0), dst: issue_dst, load: issue_load};

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = advance ? new_entry : '0;
    for (int j = 1; j < DEPTH; j++) begin
      pipe_d[j] = pipe_q[j-1];
    end
    if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j < FLUSH_STAGES) pipe_d[j] = '0;
      end
    end

    fwd_d = '0;
    if (advance) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        fwd_d[i*SEL_W +: SEL_W] = hit[i] ? (idx[i] + SEL_W'(1)) : SEL_W'(FWD_RF);
      end
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
      fwd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      fwd_q  <= fwd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fwd_sel   = fwd_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, random
// stimulus against a history-queue model, and a deep-pipe counter saturation run.
module tb_hazard_scoreboard;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int FLUSH_ST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, issue_valid, issue_wr, issue_load, flush, stall;
  logic [4:0]  issue_dst;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;

  logic        s_rst_n, s_valid, s_wr, s_ld, s_flush, s_stall;
  logic [4:0]  s_dst;
  logic [9:0]  s_src;
  logic [1:0]  s_used;
  logic [9:0]  s_fwd;
  logic [15:0] s_cnt;

  hazard_scoreboard u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_wr    (issue_wr),
    .issue_load  (issue_load),
    .issue_dst   (issue_dst),
    .src_addr    (src_addr),
    .src_used    (src_used),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  // Deep pipe with LOAD_LAT = DEPTH so a chained load stalls 31 of every 32 cycles.
  hazard_scoreboard #(.DEPTH(31), .LOAD_LAT(31)) u_sat (
    .clk         (clk),
    .rst_n       (s_rst_n),
    .issue_valid (s_valid),
    .issue_wr    (s_wr),
    .issue_load  (s_ld),
    .issue_dst   (s_dst),
    .src_addr    (s_src),
    .src_used    (s_used),
    .flush       (s_flush),
    .stall       (s_stall),
    .fwd_sel     (s_fwd),
    .stall_cnt   (s_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct {
    bit       rst_n, v, wr, ld;
    int       dst, s0, s1;
    bit [1:0] used;
    bit       fl;
    bit       e_st;
    int       e_f0, e_f1, e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit v, bit wr, bit ld, int dst, int s0, int s1,
                              bit [1:0] used, bit fl, bit est, int f0, int f1, int cnt);
    vec_t t;
    t.rst_n = r; t.v = v; t.wr = wr; t.ld = ld; t.dst = dst; t.s0 = s0; t.s1 = s1;
    t.used = used; t.fl = fl; t.e_st = est; t.e_f0 = f0; t.e_f1 = f1; t.e_cnt = cnt;
    return t;
  endfunction

  task automatic drive(input bit r, input bit v, input bit wr, input bit ld, input int dst,
                       input int s0, input int s1, input bit [1:0] used, input bit fl);
    int d, a0, a1;
    d = dst; a0 = s0; a1 = s1;
    rst_n       = r;
    issue_valid = v;
    issue_wr    = wr;
    issue_load  = ld;
    issue_dst   = d[4:0];
    src_addr    = {a1[4:0], a0[4:0]};
    src_used    = used;
    flush       = fl;
  endtask

  // Reference model: history of in-flight writers, youngest first; -1 = no write.
  int m_dst[$];
  bit m_ld[$];
  int m_fwd[2];
  int m_cnt;

  task automatic model_reset();
    m_dst.delete();
    m_ld.delete();
    for (int k = 0; k < DEPTH; k++) begin
      m_dst.push_back(-1);
      m_ld.push_back(1'b0);
    end
    m_fwd[0] = 0;
    m_fwd[1] = 0;
    m_cnt = 0;
  endtask

  task automatic model_calc(output bit st, output int nf0, output int nf1);
    int nf[2];
    bit any;
    int src;
    any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nf[i] = 0;
      src = (i == 0) ? int'(src_addr[4:0]) : int'(src_addr[9:5]);
      if (src_used[i]) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (m_dst[k] == src) begin
            if (m_ld[k] && (k < LOAD_LAT)) any = 1'b1;
            else nf[i] = k + 1;
            break;
          end
        end
      end
    end
    st  = issue_valid && !flush && any;
    nf0 = nf[0];
    nf1 = nf[1];
  endtask

  task automatic model_commit(input bit st, input int nf0, input int nf1);
    bit adv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    adv = issue_valid && !st && !flush;
    m_dst.push_front((adv && issue_wr && (issue_dst != 0)) ? int'(issue_dst) : -1);
    m_ld.push_front(adv && issue_load);
    void'(m_dst.pop_back());
    void'(m_ld.pop_back());
    if (flush) begin
      for (int k = 0; k < FLUSH_ST && k < DEPTH; k++) m_dst[k] = -1;
    end
    m_fwd[0] = adv ? nf0 : 0;
    m_fwd[1] = adv ? nf1 : 0;
    if (st && m_cnt < 65535) m_cnt++;
  endtask

  initial begin
    bit st;
    int nf0, nf1, sc, mism;

    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    s_rst_n = 0; s_valid = 0; s_wr = 0; s_ld = 0; s_dst = '0;
    s_src = '0; s_used = '0; s_flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rst_n = 1;

    //               rst v wr ld dst s0 s1 used fl  st f0 f1 cnt
    tbl.push_back(mk(1, 1, 1, 0,  8,  0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0,  8, 0, 2'b01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  8,  0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0,  8, 0, 2'b01, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0,  8, 0, 2'b01, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 2, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  0,  0, 0, 2'b01, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0,  9,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0,  9,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  0,  0, 9, 2'b10, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1,  8,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  0,  8, 0, 2'b01, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,  0,  8, 0, 2'b01, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 1, 2, 0, 2));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 1, 2, 0, 3));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 1, 1,  8,  8, 0, 2'b01, 0, 1, 2, 0, 4));
    tbl.push_back(mk(1, 1, 1, 0, 10,  0, 0, 2'b00, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 1, 1, 0, 11,  0, 0, 2'b00, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 1, 1, 0, 12,  0, 0, 2'b00, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 1, 1, 0, 14, 12, 0, 2'b01, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 1, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,  0, 12, 11, 2'b11, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 0));

    foreach (tbl[n]) begin
      drive(tbl[n].rst_n, tbl[n].v, tbl[n].wr, tbl[n].ld, tbl[n].dst,
            tbl[n].s0, tbl[n].s1, tbl[n].used, tbl[n].fl);
      #2;
      check($sformatf("vec%0d_stall", n), int'(stall), int'(tbl[n].e_st));
      check($sformatf("vec%0d_fwd0", n), int'(fwd_sel[1:0]), tbl[n].e_f0);
      check($sformatf("vec%0d_fwd1", n), int'(fwd_sel[3:2]), tbl[n].e_f1);
      check($sformatf("vec%0d_cnt", n), int'(stall_cnt), tbl[n].e_cnt);
      @(posedge clk);
      @(negedge clk);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
            $urandom_range(2) == 0, $urandom_range(7), $urandom_range(7), $urandom_range(7),
            2'($urandom_range(3)), $urandom_range(15) == 0);
      #2;
      model_calc(st, nf0, nf1);
      check("rnd_stall", int'(stall), int'(st));
      check("rnd_fwd0", int'(fwd_sel[1:0]), m_fwd[0]);
      check("rnd_fwd1", int'(fwd_sel[3:2]), m_fwd[1]);
      check("rnd_cnt", int'(stall_cnt), m_cnt);
      model_commit(st, nf0, nf1);
      @(posedge clk);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Chain of loads each reading the previous load's destination.
    s_valid = 1; s_wr = 1; s_ld = 1; s_dst = 5'd8; s_src = 10'd8; s_used = 2'b01;
    sc = 0;
    mism = 0;
    for (int c = 0; c < 80000 && sc < 66000; c++) begin
      if (c == 100) check("sat_cnt_early", int'(s_cnt), sc);
      #2;
      if (s_stall !== ((c % 32) != 0)) mism++;
      if (s_stall) sc++;
      @(posedge clk);
      @(negedge clk);
    end
    check("sat_budget", sc, 66000);
    check("sat_stall_pattern", mism, 0);
    #2;
    check("sat_cnt_hold", int'(s_cnt), 65535);
    check("sat_fwd", int'(s_fwd), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
